vga_tile_renderer: RTL and testbench

VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_tile_renderer_if.sv | 25 ++
 rtl/vga_timing.sv | 46 ++++
 rtl/vga_tile_renderer.sv | 142 ++++++++++++++
 tb/tb_vga_tile_renderer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared encodings and colour constants for the tile renderer.
package vga_pkg;

  typedef enum logic [1:0] {
    TILE_NONE = 2'd0,
    TILE_HEAD = 2'd1,
    TILE_BODY = 2'd2,
    TILE_WALL = 2'd3
  } tile_t;

  localparam int NUM_THEME_TBL = 6;

  // Index 0 sits in the least-significant slot.
  localparam logic [NUM_THEME_TBL-1:0][11:0] HEAD_TBL =
    {12'hFF0, 12'h8E9, 12'h709, 12'h790, 12'hF00, 12'hFF0};
  localparam logic [NUM_THEME_TBL-1:0][11:0] BODY_TBL =
    {12'h0F0, 12'h847, 12'hB0F, 12'h09F, 12'h0FF, 12'hF00};

  localparam logic [11:0] APPLE_COLOR  = 12'h00F;
  localparam logic [11:0] WALL_COLOR   = 12'hB55;
  localparam logic [11:0] CORNER_COLOR = 12'h000;
  localparam logic [11:0] GRID_COLOR   = 12'h111;
  localparam logic [11:0] BLANK_COLOR  = 12'h000;

  function automatic logic [11:0] theme_color(input logic [2:0] sel, input logic body);
    return body ? BODY_TBL[sel] : HEAD_TBL[sel];
  endfunction

endpackage

// File: rtl/vga_tile_renderer_if.sv
// Tile fetch and video output bundle between the renderer and its host.
interface vga_tile_renderer_if;
  logic        pix_en;
  logic [2:0]  theme;
  logic [5:0]  apple_x;
  logic [4:0]  apple_y;
  logic [5:0]  tile_x;
  logic [4:0]  tile_y;
  logic [1:0]  tile_type;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  logic [11:0] color_out;

  modport master (
    output pix_en, theme, apple_x, apple_y, tile_type,
    input  tile_x, tile_y, hsync, vsync, de, frame_start, color_out
  );

  modport slave (
    input  pix_en, theme, apple_x, apple_y, tile_type,
    output tile_x, tile_y, hsync, vsync, de, frame_start, color_out
  );
endinterface

// File: rtl/vga_timing.sv
// Raster counters with raw (unregistered) sync, active and first-pixel flags.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          first
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (int'(h) == H_TOTAL - 1) begin
        h <= '0;
        v <= (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign active  = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  assign hsync_n = !((int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC));
  assign vsync_n = !((int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC));
  assign first   = (h == '0) && (v == '0);

endmodule

// File: rtl/vga_tile_renderer.sv
// Two-stage tile renderer: tile fetch address, then colour/sync register.
// Build option: define VGA_GRID_EN to draw a 12'h111 grid on empty tiles.
module vga_tile_renderer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int TILE_LOG2 = 4,
  parameter int THEMES    = 6
) (
  input logic               clk,
  input logic               rst,
  vga_tile_renderer_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int TILE    = 1 << TILE_LOG2;

  if (((H_ACTIVE + TILE - 1) >> TILE_LOG2) > 64 ||
      ((V_ACTIVE + TILE - 1) >> TILE_LOG2) > 32) begin : g_bad_tile_grid
    $error("visible tile grid does not fit tile_x/tile_y");
  end

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          act0, hs0_n, vs0_n, first0;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .pix_en(bus.pix_en),
    .h(h), .v(v), .active(act0), .hsync_n(hs0_n), .vsync_n(vs0_n), .first(first0)
  );

  typedef struct packed {
    logic                 act;
    logic                 hs_n;
    logic                 vs_n;
    logic                 first;
    logic [TILE_LOG2-1:0] lx;
    logic [TILE_LOG2-1:0] ly;
  } s1_t;

  s1_t        s1;
  logic [5:0] tile_x_q;
  logic [4:0] tile_y_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1.act   <= 1'b0;
      s1.hs_n  <= 1'b1;
      s1.vs_n  <= 1'b1;
      s1.first <= 1'b0;
      s1.lx    <= '0;
      s1.ly    <= '0;
      tile_x_q <= '0;
      tile_y_q <= '0;
    end else if (bus.pix_en) begin
      s1.act   <= act0;
      s1.hs_n  <= hs0_n;
      s1.vs_n  <= vs0_n;
      s1.first <= first0;
      s1.lx    <= h[TILE_LOG2-1:0];
      s1.ly    <= v[TILE_LOG2-1:0];
      tile_x_q <= 6'(h >> TILE_LOG2);
      tile_y_q <= 5'(v >> TILE_LOG2);
    end
  end

  logic [11:0] none_color;
`ifdef VGA_GRID_EN
  assign none_color = (s1.lx == '0 || s1.ly == '0) ? GRID_COLOR : BLANK_COLOR;
`else
  assign none_color = BLANK_COLOR;
`endif

  // The live theme is taken on the first pixel and then held for the frame.
  logic [2:0]  theme_q, theme_eff, theme_sel;
  logic        corner, apple_hit;
  logic [11:0] pix;

  always_comb begin
    theme_eff = s1.first ? bus.theme : theme_q;
    theme_sel = (int'(theme_eff) < THEMES && int'(theme_eff) < NUM_THEME_TBL) ? theme_eff : 3'd0;
    corner    = (s1.lx == '0) && (s1.ly == '0);
    apple_hit = (tile_x_q == bus.apple_x) && (tile_y_q == bus.apple_y);
    pix       = BLANK_COLOR;
    if (s1.act) begin
      if (apple_hit) begin
        pix = corner ? CORNER_COLOR : APPLE_COLOR;
      end else begin
        case (tile_t'(bus.tile_type))
          TILE_WALL: pix = WALL_COLOR;
          TILE_HEAD, TILE_BODY:
            pix = corner ? CORNER_COLOR : theme_color(theme_sel, bus.tile_type == TILE_BODY);
          default:   pix = none_color;
        endcase
      end
    end
  end

  logic [11:0] color_q;
  logic        de_q, hs_q, vs_q, fs_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      theme_q <= '0;
    end else if (bus.pix_en) begin
      color_q <= pix;
      de_q    <= s1.act;
      hs_q    <= s1.hs_n;
      vs_q    <= s1.vs_n;
      fs_q    <= s1.first;
      theme_q <= theme_eff;
    end
  end

  assign bus.tile_x      = tile_x_q;
  assign bus.tile_y      = tile_y_q;
  assign bus.color_out   = color_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  // Gated so the pulse never lingers through strobe-less cycles.
  assign bus.frame_start = fs_q & bus.pix_en;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench: reduced raster, random tile maps, flat-index pixel model.
module tb_vga_tile_renderer;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  localparam logic [11:0] HEAD_C [6] = '{12'hFF0, 12'hF00, 12'h790, 12'h709, 12'h8E9, 12'hFF0};
  localparam logic [11:0] BODY_C [6] = '{12'hF00, 12'h0FF, 12'h09F, 12'hB0F, 12'h847, 12'h0F0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_tile_renderer_if bus();

  vga_tile_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .TILE_LOG2(4), .THEMES(6)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [1:0] tmap [0:31][0:63];
  assign bus.tile_type = tmap[bus.tile_y][bus.tile_x];

  int vec = 0, errs = 0;
  int n = 0, stride = 1, cx = 0, cy = 0, fr_thm = 0;
  bit cvalid = 0, idle_fs = 0, idle_de_chg = 0;

  // Expected pixel from raster position alone.
  function automatic logic [11:0] exp_color(int x, int y, int thm);
    int tx, ty;
    bit cor;
    tx = x / 16; ty = y / 16;
    cor = (x % 16 == 0) && (y % 16 == 0);
    if (x >= HA || y >= VA) return 12'h000;
    if (tx == int'(bus.apple_x) && ty == int'(bus.apple_y)) return cor ? 12'h000 : 12'h00F;
    case (tmap[ty][tx])
      2'd3: return 12'hB55;
      2'd1: return cor ? 12'h000 : HEAD_C[thm];
      2'd2: return cor ? 12'h000 : BODY_C[thm];
      default: ;
    endcase
`ifdef VGA_GRID_EN
    return (x % 16 == 0 || y % 16 == 0) ? 12'h111 : 12'h000;
`else
    return 12'h000;
`endif
  endfunction

  // One pixel strobe; returns at a negedge with pix_en high and model position updated.
  task automatic tick();
    logic [2:0] th;
    logic de0;
    int p;
    th = bus.theme;
    @(posedge clk); #1;
    n++;
    if (stride > 1) begin
      bus.pix_en = 1'b0;
      de0 = bus.de;
      repeat (stride - 1) begin
        @(negedge clk);
        if (bus.frame_start !== 1'b0) idle_fs = 1;
        if (bus.de !== de0) idle_de_chg = 1;
        @(posedge clk); #1;
      end
    end
    bus.pix_en = 1'b1;
    @(negedge clk);
    cvalid = (n >= 2);
    if (cvalid) begin
      p = n - 2;
      cx = p % HT;
      cy = (p / HT) % VT;
      if (cx == 0 && cy == 0) fr_thm = (int'(th) < 6) ? int'(th) : 0;
    end
  endtask

  task automatic fill_map(input int mode);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        tmap[y][x] = (mode == 0) ? 2'd0 : 2'($urandom_range(0, 3));
  endtask

  task automatic sync_frame(input string tag);
    for (int k = 0; k < FRAME + 4 && !(cvalid && cx == 0 && cy == 0); k++) tick();
    vec++;
    if (!(cvalid && cx == 0 && cy == 0)) begin
      errs++;
      $display("FAIL %s_sync got x=%0d y=%0d exp x=0 y=0", tag, cx, cy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pix_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec += 7;
    if (bus.tile_x !== 6'd0)       begin errs++; $display("FAIL rst_tile_x got %h exp 0", bus.tile_x); end
    if (bus.tile_y !== 5'd0)       begin errs++; $display("FAIL rst_tile_y got %h exp 0", bus.tile_y); end
    if (bus.color_out !== 12'h000) begin errs++; $display("FAIL rst_color got %h exp 000", bus.color_out); end
    if (bus.de !== 1'b0)           begin errs++; $display("FAIL rst_de got %b exp 0", bus.de); end
    if (bus.frame_start !== 1'b0)  begin errs++; $display("FAIL rst_fs got %b exp 0", bus.frame_start); end
    if (bus.hsync !== 1'b1)        begin errs++; $display("FAIL rst_hsync got %b exp 1", bus.hsync); end
    if (bus.vsync !== 1'b1)        begin errs++; $display("FAIL rst_vsync got %b exp 1", bus.vsync); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n = 0; cvalid = 0;
  endtask

  task automatic test_timing();
    bit ed, ehs, evs, efs;
    int hs_low = 0, de_cnt = 0, vs_lines = 0;
    fill_map(1);
    stride = 4;
    sync_frame("timing");
    idle_fs = 0; idle_de_chg = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) tick();
      ed  = (cx < HA) && (cy < VA);
      ehs = !(cx >= HA + HF && cx < HA + HF + HS);
      evs = !(cy >= VA + VF && cy < VA + VF + VS);
      efs = (cx == 0) && (cy == 0);
      vec++;
      if (bus.de !== ed || bus.hsync !== ehs || bus.vsync !== evs || bus.frame_start !== efs) begin
        errs++;
        $display("FAIL timing x=%0d y=%0d got de/hs/vs/fs=%b%b%b%b exp %b%b%b%b",
                 cx, cy, bus.de, bus.hsync, bus.vsync, bus.frame_start, ed, ehs, evs, efs);
      end
      hs_low += (bus.hsync === 1'b0) ? 1 : 0;
      de_cnt += (bus.de === 1'b1) ? 1 : 0;
      if (cx == 0 && bus.vsync === 1'b0) vs_lines++;
      if (cx == HT - 1) begin
        vec++;
        if (hs_low != HS) begin errs++; $display("FAIL hsync_width line=%0d got %0d exp %0d", cy, hs_low, HS); end
        hs_low = 0;
      end
    end
    tick();
    vec += 5;
    if (bus.frame_start !== 1'b1) begin errs++; $display("FAIL frame_period got fs=%b exp 1", bus.frame_start); end
    if (de_cnt != HA * VA)        begin errs++; $display("FAIL de_count got %0d exp %0d", de_cnt, HA * VA); end
    if (vs_lines != VS)           begin errs++; $display("FAIL vsync_lines got %0d exp %0d", vs_lines, VS); end
    if (idle_fs)                  begin errs++; $display("FAIL idle_fs got 1 exp 0"); end
    if (idle_de_chg)              begin errs++; $display("FAIL idle_hold got change exp hold"); end
    stride = 1;
  endtask

  task automatic test_apple_grid();
    logic [11:0] ec;
    fill_map(0);
    bus.apple_x = 6'd3; bus.apple_y = 5'd2;
    bus.theme = 3'($urandom_range(0, 7));
    sync_frame("apple");
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) tick();
      ec = exp_color(cx, cy, fr_thm);
      vec++;
      if (bus.color_out !== ec) begin
        errs++; $display("FAIL apple x=%0d y=%0d got %h exp %h", cx, cy, bus.color_out, ec);
      end
      if (cx == 48 && cy == 32) begin
        vec++;
        if (bus.color_out !== 12'h000) begin errs++; $display("FAIL apple_corner got %h exp 000", bus.color_out); end
      end
      if ((cx == 49 && cy == 32) || (cx == 63 && cy == 47)) begin
        vec++;
        if (bus.color_out !== 12'h00F) begin errs++; $display("FAIL apple_edge x=%0d got %h exp 00F", cx, bus.color_out); end
      end
    end
  endtask

  task automatic test_theme();
    logic [11:0] ec, spot;
    fill_map(0);
    tmap[0][0] = 2'd1;
    bus.apple_x = 6'd63; bus.apple_y = 5'd31;
    bus.theme = 3'd2;
    sync_frame("theme");
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k > 0) tick();
      ec = exp_color(cx, cy, fr_thm);
      vec++;
      if (bus.color_out !== ec) begin
        errs++; $display("FAIL theme x=%0d y=%0d got %h exp %h", cx, cy, bus.color_out, ec);
      end
      if ((cx == 1 && cy == 0) || (cx == 0 && cy == 0)) begin
        spot = (cx == 0) ? 12'h000 : ((k < FRAME) ? 12'h790 : 12'hFF0);
        vec++;
        if (bus.color_out !== spot) begin
          errs++; $display("FAIL theme_spot x=%0d k=%0d got %h exp %h", cx, k, bus.color_out, spot);
        end
      end
      if (k < FRAME && cx == 0 && cy == 20) bus.theme = 3'd7;
    end
  endtask

  task automatic test_random();
    logic [11:0] ec;
    fill_map(1);
    bus.apple_x = 6'($urandom_range(0, 5));
    bus.apple_y = 5'($urandom_range(0, 3));
    bus.theme = 3'($urandom_range(0, 7));
    sync_frame("random");
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k > 0) tick();
      ec = exp_color(cx, cy, fr_thm);
      vec++;
      if (bus.color_out !== ec || bus.de !== (cx < HA && cy < VA)) begin
        errs++; $display("FAIL random x=%0d y=%0d got %h/%b exp %h", cx, cy, bus.color_out, bus.de, ec);
      end
      if ($urandom_range(0, 499) == 0) bus.theme = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] ec;
    for (int k = 0; k < 2 * FRAME && !(cvalid && cx == 30 && cy == 20); k++) tick();
    vec++;
    if (!(cvalid && cx == 30 && cy == 20)) begin errs++; $display("FAIL rmid_reach got x=%0d y=%0d exp 30,20", cx, cy); end
    rst = 1'b0;
    #1;
    vec += 3;
    if (bus.de !== 1'b0 || bus.color_out !== 12'h000) begin
      errs++; $display("FAIL rmid_out got de=%b color=%h exp 0/000", bus.de, bus.color_out);
    end
    if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
      errs++; $display("FAIL rmid_sync got %b%b exp 11", bus.hsync, bus.vsync);
    end
    if (bus.tile_x !== 6'd0 || bus.tile_y !== 5'd0) begin
      errs++; $display("FAIL rmid_tile got %h,%h exp 0,0", bus.tile_x, bus.tile_y);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n = 0; cvalid = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      vec++;
      if (bus.frame_start !== (k == 2)) begin
        errs++; $display("FAIL rmid_fs n=%0d got %b exp %b", n, bus.frame_start, k == 2);
      end
    end
    ec = exp_color(0, 0, fr_thm);
    vec++;
    if (bus.de !== 1'b1 || bus.color_out !== ec) begin
      errs++; $display("FAIL rmid_first got de=%b color=%h exp 1/%h", bus.de, bus.color_out, ec);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_en = 1'b0;
    bus.theme = 3'd0;
    bus.apple_x = 6'd63;
    bus.apple_y = 5'd31;
    fill_map(0);
    test_reset();
    test_timing();
    test_apple_grid();
    test_theme();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
